// File: rtl/ddr3_read_checker_multi.sv
// DDR3 read-back checker: after calibration, compares each read beat with SEED ^ index.
// Define READ_CHECKER_CAPTURE_EN to add first-mismatch expected/actual capture ports.
module ddr3_read_checker_multi #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          COUNT_WIDTH    = 24,
    parameter logic [63:0] SEED           = 64'hdeadfadebabebeef,
    parameter int          MAX_ERRORS     = 1,
    parameter int          ERR_WIDTH      = 16,
    parameter int          TIMEOUT_CYCLES = 65536
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   avl_rdata_valid,
    input  logic [DATA_WIDTH-1:0]  avl_rdata,
    input  logic                   ddr3_init_done,
    input  logic                   ddr3_cal_success,
    input  logic                   ddr3_cal_fail,
    output logic                   is_finished,
    output logic                   pass,
    output logic                   fail,
    output logic [1:0]             fail_reason,
    output logic [ERR_WIDTH-1:0]   error_count,
    output logic [COUNT_WIDTH:0]   words_checked,
    output logic [COUNT_WIDTH-1:0] first_error_index
`ifdef READ_CHECKER_CAPTURE_EN
    ,
    output logic [DATA_WIDTH-1:0]  first_error_expected,
    output logic [DATA_WIDTH-1:0]  first_error_actual
`endif
);

    localparam logic [1:0] ST_WAIT_INIT = 2'd0;
    localparam logic [1:0] ST_CHECK     = 2'd1;
    localparam logic [1:0] ST_DONE_PASS = 2'd2;
    localparam logic [1:0] ST_DONE_FAIL = 2'd3;

    localparam logic [1:0] RSN_CAL      = 2'd1;
    localparam logic [1:0] RSN_MISMATCH = 2'd2;
    localparam logic [1:0] RSN_TIMEOUT  = 2'd3;

    localparam int                    IDLE_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]     IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam int                    CMP_W     = ((ERR_WIDTH > 32) ? ERR_WIDTH : 32) + 1;
    localparam logic [DATA_WIDTH-1:0] SEED_W    = SEED[DATA_WIDTH-1:0];
    localparam logic [ERR_WIDTH-1:0]  ERR_SAT   = '1;

    logic [1:0]             state_q, state_d;
    logic                   finished_q, finished_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic [1:0]             reason_q, reason_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic [COUNT_WIDTH:0]   words_q, words_d;
    logic [COUNT_WIDTH-1:0] first_idx_q, first_idx_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;

    logic [DATA_WIDTH-1:0]  expected_word;
    logic [ERR_WIDTH-1:0]   err_inc;
    logic                   beat_checked;
    logic                   mismatch;
    logic                   first_mismatch;

    assign expected_word  = SEED_W ^ DATA_WIDTH'(words_q[COUNT_WIDTH-1:0]);
    assign err_inc        = (err_q == ERR_SAT) ? err_q : err_q + ERR_WIDTH'(1);
    assign beat_checked   = (state_q == ST_CHECK) && !words_q[COUNT_WIDTH] && avl_rdata_valid;
    assign mismatch       = beat_checked && (avl_rdata != expected_word);
    assign first_mismatch = mismatch && (err_q == '0);

    // NOTE: every _d starts as its _q, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        finished_d  = finished_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        reason_d    = reason_q;
        err_d       = err_q;
        words_d     = words_q;
        first_idx_d = first_idx_q;
        idle_d      = idle_q;

        case (state_q)
            ST_WAIT_INIT: begin
                if (ddr3_init_done && ddr3_cal_success) begin
                    state_d = ST_CHECK;
                end else if (ddr3_init_done && ddr3_cal_fail) begin
                    state_d    = ST_DONE_FAIL;
                    finished_d = 1'b1;
                    fail_d     = 1'b1;
                    reason_d   = RSN_CAL;
                end
            end
            ST_CHECK: begin
                if (words_q[COUNT_WIDTH]) begin
                    finished_d = 1'b1;
                    if (err_q == '0) begin
                        state_d = ST_DONE_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d  = ST_DONE_FAIL;
                        fail_d   = 1'b1;
                        reason_d = RSN_MISMATCH;
                    end
                end else if (avl_rdata_valid) begin
                    // A beat in the watchdog expiry cycle is checked and cancels the timeout.
                    words_d = words_q + (COUNT_WIDTH + 1)'(1);
                    idle_d  = '0;
                    if (mismatch) begin
                        err_d = err_inc;
                        if (first_mismatch) begin
                            first_idx_d = words_q[COUNT_WIDTH-1:0];
                        end
                        if (CMP_W'(err_inc) >= CMP_W'(MAX_ERRORS)) begin
                            state_d    = ST_DONE_FAIL;
                            finished_d = 1'b1;
                            fail_d     = 1'b1;
                            reason_d   = RSN_MISMATCH;
                        end
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d    = ST_DONE_FAIL;
                        finished_d = 1'b1;
                        fail_d     = 1'b1;
                        reason_d   = RSN_TIMEOUT;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_INIT;
            finished_q  <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            reason_q    <= '0;
            err_q       <= '0;
            words_q     <= '0;
            first_idx_q <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            finished_q  <= finished_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            reason_q    <= reason_d;
            err_q       <= err_d;
            words_q     <= words_d;
            first_idx_q <= first_idx_d;
            idle_q      <= idle_d;
        end
    end

    assign is_finished       = finished_q;
    assign pass              = pass_q;
    assign fail              = fail_q;
    assign fail_reason       = reason_q;
    assign error_count       = err_q;
    assign words_checked     = words_q;
    assign first_error_index = first_idx_q;

`ifdef READ_CHECKER_CAPTURE_EN
    logic [DATA_WIDTH-1:0] cap_exp_q;
    logic [DATA_WIDTH-1:0] cap_act_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_exp_q <= '0;
            cap_act_q <= '0;
        end else if (first_mismatch) begin
            cap_exp_q <= expected_word;
            cap_act_q <= avl_rdata;
        end
    end

    assign first_error_expected = cap_exp_q;
    assign first_error_actual   = cap_act_q;
`else
    // Without capture, the first-mismatch strobe only selects first_error_index.
`endif

endmodule

// File: tb/tb_ddr3_read_checker_multi.sv
// Bench for ddr3_read_checker_multi: three configurations share randomized stimulus and are
// checked every cycle against a behavioural model, plus hand-computed directed expectations.
module tb_ddr3_read_checker_multi;

    localparam logic [63:0] SEED     = 64'hdeadfadebabebeef;
    localparam int          TEST_LEN = 16;

    typedef struct {
        bit          checking;
        bit          finished;
        bit          passed;
        int          reason;
        int          errs;
        int          words;
        int          first_idx;
        int          idle;
        logic [15:0] cap_exp;
        logic [15:0] cap_act;
    } model_t;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        valid     = 1'b0;
    logic [15:0] rdata     = '0;
    logic        init_done = 1'b0;
    logic        cal_succ  = 1'b0;
    logic        cal_fail  = 1'b0;

    logic        a_fin, a_pass, a_fail, b_fin, b_pass, b_fail, c_fin, c_pass, c_fail;
    logic [1:0]  a_rsn, b_rsn, c_rsn;
    logic [15:0] a_err, b_err;
    logic [1:0]  c_err;
    logic [4:0]  a_wc, b_wc, c_wc;
    logic [3:0]  a_fi, b_fi, c_fi;
`ifdef READ_CHECKER_CAPTURE_EN
    logic [15:0] a_cexp, a_cact, b_cexp, b_cact, c_cexp, c_cact;
`endif

    int     n_tests = 0;
    int     n_fails = 0;
    int     bidx    = 0;
    bit     cmp_en  = 1'b0;
    model_t m_a, m_b, m_c;

    always #5 clk = ~clk;

    ddr3_read_checker_multi #(.DATA_WIDTH(16), .COUNT_WIDTH(4), .SEED(SEED), .MAX_ERRORS(1),
                              .ERR_WIDTH(16), .TIMEOUT_CYCLES(8)) u_a (
        .clk(clk), .reset_n(reset_n), .avl_rdata_valid(valid), .avl_rdata(rdata),
        .ddr3_init_done(init_done), .ddr3_cal_success(cal_succ), .ddr3_cal_fail(cal_fail),
        .is_finished(a_fin), .pass(a_pass), .fail(a_fail), .fail_reason(a_rsn),
        .error_count(a_err), .words_checked(a_wc), .first_error_index(a_fi)
`ifdef READ_CHECKER_CAPTURE_EN
        , .first_error_expected(a_cexp), .first_error_actual(a_cact)
`endif
    );

    ddr3_read_checker_multi #(.DATA_WIDTH(16), .COUNT_WIDTH(4), .SEED(SEED), .MAX_ERRORS(4),
                              .ERR_WIDTH(16), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .reset_n(reset_n), .avl_rdata_valid(valid), .avl_rdata(rdata),
        .ddr3_init_done(init_done), .ddr3_cal_success(cal_succ), .ddr3_cal_fail(cal_fail),
        .is_finished(b_fin), .pass(b_pass), .fail(b_fail), .fail_reason(b_rsn),
        .error_count(b_err), .words_checked(b_wc), .first_error_index(b_fi)
`ifdef READ_CHECKER_CAPTURE_EN
        , .first_error_expected(b_cexp), .first_error_actual(b_cact)
`endif
    );

    ddr3_read_checker_multi #(.DATA_WIDTH(16), .COUNT_WIDTH(4), .SEED(SEED), .MAX_ERRORS(5),
                              .ERR_WIDTH(2), .TIMEOUT_CYCLES(0)) u_c (
        .clk(clk), .reset_n(reset_n), .avl_rdata_valid(valid), .avl_rdata(rdata),
        .ddr3_init_done(init_done), .ddr3_cal_success(cal_succ), .ddr3_cal_fail(cal_fail),
        .is_finished(c_fin), .pass(c_pass), .fail(c_fail), .fail_reason(c_rsn),
        .error_count(c_err), .words_checked(c_wc), .first_error_index(c_fi)
`ifdef READ_CHECKER_CAPTURE_EN
        , .first_error_expected(c_cexp), .first_error_actual(c_cact)
`endif
    );

    function automatic model_t model_reset();
        model_t m;
        m.checking = 0; m.finished = 0; m.passed = 0; m.reason = 0; m.errs = 0;
        m.words = 0; m.first_idx = 0; m.idle = 0; m.cap_exp = '0; m.cap_act = '0;
        return m;
    endfunction

    // One clock of the checker's rules, written in terms of run progress rather than states.
    function automatic model_t model_step(input model_t m, input int max_err, input int err_max,
                                          input int timeout, input bit ini, input bit suc,
                                          input bit cfl, input bit v, input logic [15:0] d);
        model_t n;
        logic [15:0] exp_word;
        n = m;
        if (m.finished) return n;
        if (!m.checking) begin
            if (ini && suc) n.checking = 1;
            else if (ini && cfl) begin n.finished = 1; n.reason = 1; end
            return n;
        end
        if (m.words == TEST_LEN) begin
            n.finished = 1;
            if (m.errs == 0) n.passed = 1;
            else n.reason = 2;
        end else if (v) begin
            exp_word = SEED[15:0] ^ 16'(m.words);
            n.words  = m.words + 1;
            n.idle   = 0;
            if (d !== exp_word) begin
                if (m.errs == 0) begin
                    n.first_idx = m.words; n.cap_exp = exp_word; n.cap_act = d;
                end
                n.errs = (m.errs < err_max) ? m.errs + 1 : err_max;
                if (n.errs >= max_err) begin n.finished = 1; n.reason = 2; end
            end
        end else if (timeout > 0) begin
            if (m.idle == timeout - 1) begin n.finished = 1; n.reason = 3; end
            else n.idle = m.idle + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_a <= model_reset();
            m_b <= model_reset();
            m_c <= model_reset();
        end else begin
            m_a <= model_step(m_a, 1, 65535, 8, init_done, cal_succ, cal_fail, valid, rdata);
            m_b <= model_step(m_b, 4, 65535, 0, init_done, cal_succ, cal_fail, valid, rdata);
            m_c <= model_step(m_c, 5, 3,     0, init_done, cal_succ, cal_fail, valid, rdata);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_dut(input int which, input string tag, input bit fin, input bit ps,
                              input bit fl, input int rs, input int ec, input int wc, input int fi);
        logic f_fin, f_ps, f_fl;
        logic [1:0] f_rs;
        logic [15:0] f_ec;
        logic [4:0] f_wc;
        logic [3:0] f_fi;
        case (which)
            0:       begin f_fin = a_fin; f_ps = a_pass; f_fl = a_fail; f_rs = a_rsn; f_ec = a_err;
                           f_wc = a_wc; f_fi = a_fi; end
            1:       begin f_fin = b_fin; f_ps = b_pass; f_fl = b_fail; f_rs = b_rsn; f_ec = b_err;
                           f_wc = b_wc; f_fi = b_fi; end
            default: begin f_fin = c_fin; f_ps = c_pass; f_fl = c_fail; f_rs = c_rsn;
                           f_ec = 16'(c_err); f_wc = c_wc; f_fi = c_fi; end
        endcase
        check({tag, ".is_finished"},       64'(f_fin), 64'(fin));
        check({tag, ".pass"},              64'(f_ps),  64'(ps));
        check({tag, ".fail"},              64'(f_fl),  64'(fl));
        check({tag, ".fail_reason"},       64'(f_rs),  64'(rs));
        check({tag, ".error_count"},       64'(f_ec),  64'(ec));
        check({tag, ".words_checked"},     64'(f_wc),  64'(wc));
        check({tag, ".first_error_index"}, 64'(f_fi),  64'(fi));
    endtask

    task automatic expect_model(input int which, input string tag, input model_t m);
        expect_dut(which, tag, m.finished, m.passed, m.finished && !m.passed, m.reason, m.errs,
                   m.words, m.first_idx);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            expect_model(0, "cyc.a", m_a);
            expect_model(1, "cyc.b", m_b);
            expect_model(2, "cyc.c", m_c);
`ifdef READ_CHECKER_CAPTURE_EN
            check("cyc.a.cap_exp", 64'(a_cexp), 64'(m_a.cap_exp));
            check("cyc.a.cap_act", 64'(a_cact), 64'(m_a.cap_act));
            check("cyc.b.cap_exp", 64'(b_cexp), 64'(m_b.cap_exp));
            check("cyc.b.cap_act", 64'(b_cact), 64'(m_b.cap_act));
            check("cyc.c.cap_exp", 64'(c_cexp), 64'(m_c.cap_exp));
            check("cyc.c.cap_act", 64'(c_cact), 64'(m_c.cap_act));
`endif
        end
    end

    task automatic cyc(input bit v, input logic [15:0] d);
        @(negedge clk);
        valid = v;
        rdata = d;
    endtask

    task automatic send_beat(input bit corrupt, input int flip);
        logic [15:0] w;
        w = SEED[15:0] ^ 16'(bidx);
        if (corrupt) w[flip] = ~w[flip];
        cyc(1'b1, w);
        bidx++;
    endtask

    task automatic send_good(input int count, input int max_gap);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, max_gap)) cyc(1'b0, 16'($urandom));
            send_beat(1'b0, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0; valid = 1'b0; init_done = 1'b0; cal_succ = 1'b0; cal_fail = 1'b0;
        bidx = 0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic calibrate(input int delay);
        repeat (delay) cyc(1'b0, '0);
        cyc(1'b0, '0);
        init_done = 1'b1;
        cal_succ  = 1'b1;
        bidx      = 0;
    endtask

    task automatic expect_all_reset(input string tag);
        expect_dut(0, {tag, ".a"}, 0, 0, 0, 0, 0, 0, 0);
        expect_dut(1, {tag, ".b"}, 0, 0, 0, 0, 0, 0, 0);
        expect_dut(2, {tag, ".c"}, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;
        #1 expect_all_reset("reset");

        // Good run: calibration after 10 cycles, 16 correct beats with short gaps.
        calibrate(10);
        send_good(16, 3);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1;
        expect_dut(0, "good.a", 1, 1, 0, 0, 0, 16, 0);
        expect_dut(1, "good.b", 1, 1, 0, 0, 0, 16, 0);
        expect_dut(2, "good.c", 1, 1, 0, 0, 0, 16, 0);

        // Calibration failure, then beats that must be ignored.
        do_reset();
        cyc(1'b0, '0);
        init_done = 1'b1; cal_fail = 1'b1;
        cyc(1'b0, '0);
        #1 expect_dut(0, "calfail.a", 1, 0, 1, 1, 0, 0, 0);
        send_good(3, 0);
        cyc(1'b0, '0);
        #1 expect_dut(1, "calfail.b", 1, 0, 1, 1, 0, 0, 0);

        // Success and failure together: success wins.
        do_reset();
        cyc(1'b0, '0);
        init_done = 1'b1; cal_succ = 1'b1; cal_fail = 1'b1; bidx = 0;
        cyc(1'b0, '0);
        #1 expect_dut(0, "both.a", 0, 0, 0, 0, 0, 0, 0);
        send_good(16, 1);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1 expect_dut(0, "both_end.a", 1, 1, 0, 0, 0, 16, 0);

        // Beat 5 corrupted in bit 0.
        do_reset();
        calibrate(2);
        send_good(5, 0);
        send_beat(1'b1, 0);
        cyc(1'b0, '0);
        #1 expect_dut(0, "beat5.a", 1, 0, 1, 2, 1, 6, 5);
        send_good(10, 0);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1;
        expect_dut(1, "beat5.b", 1, 0, 1, 2, 1, 16, 5);
        expect_dut(2, "beat5.c", 1, 0, 1, 2, 1, 16, 5);

        // Beats 2 and 9 corrupted: unit b consumes all 16 before failing.
        do_reset();
        calibrate(0);
        for (int i = 0; i < TEST_LEN; i++) send_beat(i == 2 || i == 9, 0);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1;
        expect_dut(0, "b2b9.a", 1, 0, 1, 2, 1, 3, 2);
        expect_dut(1, "b2b9.b", 1, 0, 1, 2, 2, 16, 2);
`ifdef READ_CHECKER_CAPTURE_EN
        check("b2b9.b.cap_exp", 64'(b_cexp), 64'hbeed);
        check("b2b9.b.cap_act", 64'(b_cact), 64'hbeec);
`endif

        // Watchdog: 3 beats then silence; failure lands exactly 8 cycles after the last beat.
        do_reset();
        calibrate(0);
        send_good(3, 0);
        repeat (8) cyc(1'b0, '0);
        #1 expect_dut(0, "wd_pre.a", 0, 0, 0, 0, 0, 3, 0);
        cyc(1'b0, '0);
        #1;
        expect_dut(0, "wd.a", 1, 0, 1, 3, 0, 3, 0);
        expect_dut(1, "wd.b", 0, 0, 0, 0, 0, 3, 0);

        // Beat in the expiry cycle cancels the timeout.
        do_reset();
        calibrate(0);
        send_good(3, 0);
        repeat (7) cyc(1'b0, '0);
        send_beat(1'b0, 0);
        cyc(1'b0, '0);
        #1 expect_dut(0, "wd_save.a", 0, 0, 0, 0, 0, 4, 0);
        send_good(12, 2);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1 expect_dut(0, "wd_save_end.a", 1, 1, 0, 0, 0, 16, 0);

        // Asynchronous reset mid-run after 7 beats, then a full good rerun.
        do_reset();
        calibrate(1);
        send_good(7, 0);
        cyc(1'b0, '0);
        #1 expect_dut(0, "mid_pre.a", 0, 0, 0, 0, 0, 7, 0);
        #1 reset_n = 1'b0;
        #1 expect_all_reset("mid_async");
        @(negedge clk);
        #2 reset_n = 1'b1;
        calibrate(3);
        send_good(16, 2);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1 expect_dut(0, "rerun.a", 1, 1, 0, 0, 0, 16, 0);

        // Every beat corrupted: b aborts on its 4th error, c saturates at 3 and runs to the end.
        do_reset();
        calibrate(0);
        for (int i = 0; i < TEST_LEN; i++) send_beat(1'b1, i);
        cyc(1'b0, '0); cyc(1'b0, '0);
        #1;
        expect_dut(0, "allbad.a", 1, 0, 1, 2, 1, 1, 0);
        expect_dut(1, "allbad.b", 1, 0, 1, 2, 4, 4, 0);
        expect_dut(2, "allbad.c", 1, 0, 1, 2, 3, 16, 0);

        // Randomized runs checked cycle by cycle against the model.
        for (int run = 0; run < 40; run++) begin
            int r;
            int nb;
            int gap;
            do_reset();
            repeat ($urandom_range(0, 5)) cyc(1'b0, '0);
            r = int'($urandom_range(0, 9));
            cyc(1'b0, '0);
            if (r == 0) begin
                init_done = 1'b1; cal_fail = 1'b1;
            end else if (r == 1) begin
                init_done = 1'b1; cal_succ = 1'b1; cal_fail = 1'b1;
            end else if (r == 2) begin
                cal_succ = 1'b1;
                repeat (3) cyc(1'b0, '0);
                init_done = 1'b1;
            end else begin
                init_done = 1'b1; cal_succ = 1'b1;
            end
            bidx = 0;
            nb = int'($urandom_range(10, 20));
            for (int i = 0; i < nb; i++) begin
                gap = int'($urandom_range(0, 3));
                if ($urandom_range(0, 11) == 0) gap = int'($urandom_range(6, 9));
                repeat (gap) cyc(1'b0, 16'($urandom));
                if ($urandom_range(0, 49) == 0) begin
                    do_reset();
                    calibrate(1);
                end
                send_beat($urandom_range(0, 11) == 0, int'($urandom_range(0, 15)));
            end
            repeat (3) cyc(1'b0, '0);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
